// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - fetch PC owner, hazard detection, stage hold/flush and ALU forwarding
module pipeline_hazard_ctrl #(
   parameter int          LOAD_STALL = 1,
   parameter logic [4:0]  HALT_PC    = 5'd16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       dec_valid,
   input  logic [2:0] dec_op,
   input  logic [4:0] dec_rs1,
   input  logic [4:0] dec_rs2,
   input  logic [4:0] dec_imm,
   input  logic       beq_equal,
   input  logic       ex_valid,
   input  logic [2:0] ex_op,
   input  logic [4:0] ex_rd,
   input  logic       wb_valid,
   input  logic [2:0] wb_op,
   input  logic [4:0] wb_rd,
   output logic [4:0] pc,
   output logic [2:0] hold,
   output logic [2:0] flush,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
   output logic       halted,
   output logic [7:0] stall_count
);

   localparam logic [2:0] OP_LI  = 3'd0;
   localparam logic [2:0] OP_ADI = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_CMP = 3'd3;
   localparam logic [2:0] OP_LW  = 3'd4;
   localparam logic [2:0] OP_ST  = 3'd5;
   localparam logic [2:0] OP_J   = 3'd6;
   localparam logic [2:0] OP_BEQ = 3'd7;

   localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_STALL    = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_HALT     = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] pc_q, pc_d;
   logic [2:0] hold_q, hold_d;
   logic [2:0] flush_q, flush_d;
   logic       halted_q, halted_d;
   logic [7:0] stall_count_q, stall_count_d;

   function automatic logic is_writer(input logic [2:0] op);
      return (op == OP_LI) || (op == OP_ADI) || (op == OP_ADD) || (op == OP_LW);
   endfunction

   function automatic logic reads_rs1(input logic [2:0] op);
      return (op == OP_ADI) || (op == OP_ADD) || (op == OP_CMP) || (op == OP_LW) ||
             (op == OP_ST) || (op == OP_BEQ);
   endfunction

   function automatic logic reads_rs2(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_CMP) || (op == OP_ST) || (op == OP_BEQ);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      if (src == 5'd0)
         return 2'd0;
      if (ex_valid && is_writer(ex_op) && (ex_op != OP_LW) && (ex_rd == src))
         return 2'd1;
      if (wb_valid && is_writer(wb_op) && (wb_rd == src))
         return 2'd2;
      return 2'd0;
   endfunction

   logic load_use;
   logic taken;

   // Hazard detection on the instruction currently sitting in DEC
   always_comb begin
      load_use = dec_valid && ex_valid && (ex_op == OP_LW) && (ex_rd != 5'd0) &&
                 ((reads_rs1(dec_op) && (dec_rs1 == ex_rd)) ||
                  (reads_rs2(dec_op) && (dec_rs2 == ex_rd)));
      taken    = dec_valid && ((dec_op == OP_J) || ((dec_op == OP_BEQ) && beq_equal));
   end

   // Next-state, next-PC and the registered hold/flush/halt/stall-count values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      unique case (state_q)
         ST_RUN: begin
            if (pc_q == HALT_PC) begin
               state_d = ST_HALT;
            end else if (load_use) begin
               state_d = ST_STALL;
               cnt_d   = STALL_INIT;
            end else if (taken) begin
               state_d = ST_REDIRECT;
               pc_d    = dec_imm;
            end else begin
               pc_d = pc_q + 5'd1;
            end
         end
         ST_STALL: begin
            if (cnt_q == 4'd0)
               state_d = ST_RUN;
            else
               cnt_d = cnt_q - 4'd1;
         end
         ST_REDIRECT: begin
            if (pc_q == HALT_PC) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
               pc_d    = pc_q + 5'd1;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      hold_d        = 3'b000;
      flush_d       = 3'b000;
      halted_d      = 1'b0;
      stall_count_d = stall_count_q;
      unique case (state_d)
         ST_STALL: begin
            hold_d  = 3'b001;
            flush_d = 3'b010;
            if (stall_count_q != 8'hff)
               stall_count_d = stall_count_q + 8'd1;
         end
         ST_REDIRECT: flush_d = 3'b001;
         ST_HALT: begin
            hold_d   = 3'b111;
            halted_d = 1'b1;
         end
         default: ;
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= ST_RUN;
         cnt_q         <= 4'd0;
         pc_q          <= 5'd0;
         hold_q        <= 3'b000;
         flush_q       <= 3'b000;
         halted_q      <= 1'b0;
         stall_count_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pc_q          <= pc_d;
         hold_q        <= hold_d;
         flush_q       <= flush_d;
         halted_q      <= halted_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Forwarding selects follow the current stage contents; held at 0 during reset
   always_comb begin
      fwd_a = reset_n ? fwd_sel(dec_rs1) : 2'd0;
      fwd_b = reset_n ? fwd_sel(dec_rs2) : 2'd0;
   end

   assign pc          = pc_q;
   assign hold        = hold_q;
   assign flush       = flush_q;
   assign halted      = halted_q;
   assign stall_count = stall_count_q;

endmodule
